// File: rtl/branch_ctrl.sv
// EX-stage control-transfer sequencer: resolves branch/JAL/JALR, redirects fetch, then flushes the front end.
// Optional performance counters are enabled with `define BRANCH_CTRL_PERF_EN.
module branch_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid_i,
  output logic            op_ready_o,
  input  logic [1:0]      kind_i,
  input  logic [2:0]      fun3_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            pred_taken_i,
  output logic            redir_valid_o,
  input  logic            redir_ready_i,
  output logic [XLEN-1:0] redir_pc_o,
  output logic            flush_o,
  output logic            done_o,
  output logic            taken_o,
  output logic [XLEN-1:0] link_o,
  output logic            misalign_o,
`ifdef BRANCH_CTRL_PERF_EN
  output logic [31:0]     perf_branches_o,
  output logic [31:0]     perf_taken_o,
  output logic [31:0]     perf_mispred_o,
`endif
  output logic            illegal_o
);

  typedef enum logic [1:0] {IDLE, EVAL, REDIR, FLUSH} state_t;

  localparam logic [1:0] KIND_BR   = 2'b00;
  localparam logic [1:0] KIND_JAL  = 2'b01;
  localparam logic [1:0] KIND_JALR = 2'b10;
  localparam logic [1:0] KIND_RSVD = 2'b11;

  state_t            state_q, state_d;
  logic [1:0]        kind_q, kind_d;
  logic [2:0]        fun3_q, fun3_d;
  logic [XLEN-1:0]   pc_q, pc_d, imm_q, imm_d, a_q, a_d, b_q, b_d;
  logic              pred_q, pred_d;
  logic              taken_q, taken_d;
  logic [XLEN-1:0]   link_q, link_d, redir_pc_q, redir_pc_d;
  logic [3:0]        cnt_q, cnt_d;

  logic              cond_c, illegal_c, taken_c, need_c, misalign_c, retire_eval_c;
  logic              handshake_c, done_c;
  logic [XLEN-1:0]   target_c, link_c, rpc_c, jalr_sum_c;

  // Resolution datapath, evaluated from the registered op while in EVAL.
  always_comb begin
    cond_c = 1'b0;
    case (fun3_q)
      3'b000:  cond_c = (a_q == b_q);
      3'b001:  cond_c = (a_q != b_q);
      3'b100:  cond_c = ($signed(a_q) <  $signed(b_q));
      3'b101:  cond_c = ($signed(a_q) >= $signed(b_q));
      3'b110:  cond_c = (a_q <  b_q);
      3'b111:  cond_c = (a_q >= b_q);
      default: cond_c = 1'b0;
    endcase
    illegal_c  = (kind_q == KIND_RSVD) ||
                 ((kind_q == KIND_BR) && (fun3_q == 3'b010 || fun3_q == 3'b011));
    taken_c    = illegal_c ? 1'b0 : ((kind_q == KIND_BR) ? cond_c : 1'b1);
    jalr_sum_c = a_q + imm_q;
    target_c   = (kind_q == KIND_JALR) ? {jalr_sum_c[XLEN-1:1], 1'b0} : (pc_q + imm_q);
    link_c     = pc_q + XLEN'(4);
    rpc_c      = taken_c ? target_c : link_c;
    need_c     = !illegal_c && ((kind_q == KIND_JAL) || (kind_q == KIND_JALR) || (taken_c != pred_q));
    misalign_c = need_c && (rpc_c[1:0] != 2'b00);
    retire_eval_c = illegal_c || misalign_c || !need_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      kind_q     <= '0;
      fun3_q     <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      pred_q     <= 1'b0;
      taken_q    <= 1'b0;
      link_q     <= '0;
      redir_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      fun3_q     <= fun3_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      a_q        <= a_d;
      b_q        <= b_d;
      pred_q     <= pred_d;
      taken_q    <= taken_d;
      link_q     <= link_d;
      redir_pc_q <= redir_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    fun3_d     = fun3_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    a_d        = a_q;
    b_d        = b_q;
    pred_d     = pred_q;
    taken_d    = taken_q;
    link_d     = link_q;
    redir_pc_d = redir_pc_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: if (op_valid_i) begin
        kind_d  = kind_i;
        fun3_d  = fun3_i;
        pc_d    = pc_i;
        imm_d   = imm_i;
        a_d     = op_a_i;
        b_d     = op_b_i;
        pred_d  = pred_taken_i;
        state_d = EVAL;
      end
      EVAL: begin
        taken_d    = taken_c;
        link_d     = link_c;
        redir_pc_d = rpc_c;
        state_d    = retire_eval_c ? IDLE : REDIR;
      end
      REDIR: if (redir_ready_i) begin
        cnt_d   = 4'(FLUSH_CYCLES);
        state_d = FLUSH;
      end
      FLUSH: begin
        if (cnt_q == 4'd1) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    handshake_c   = (state_q == REDIR) && redir_ready_i;
    done_c        = ((state_q == EVAL) && retire_eval_c) || handshake_c;
    op_ready_o    = (state_q == IDLE);
    redir_valid_o = (state_q == REDIR);
    redir_pc_o    = (state_q == REDIR) ? redir_pc_q : '0;
    flush_o       = (state_q == FLUSH);
    done_o        = done_c;
    // During EVAL the freshly resolved values are forwarded so they line up with done_o.
    taken_o       = (state_q == EVAL) ? taken_c : taken_q;
    link_o        = (state_q == EVAL) ? link_c  : link_q;
    misalign_o    = (state_q == EVAL) && misalign_c;
    illegal_o     = (state_q == EVAL) && illegal_c;
  end

`ifdef BRANCH_CTRL_PERF_EN
  logic [31:0] perf_br_q, perf_br_d, perf_tk_q, perf_tk_d, perf_mp_q, perf_mp_d;

  always_comb begin
    perf_br_d = perf_br_q;
    perf_tk_d = perf_tk_q;
    perf_mp_d = perf_mp_q;
    if (done_c && kind_q == KIND_BR && perf_br_q != 32'hFFFF_FFFF) perf_br_d = perf_br_q + 32'd1;
    if (done_c && kind_q == KIND_BR && taken_o && perf_tk_q != 32'hFFFF_FFFF) perf_tk_d = perf_tk_q + 32'd1;
    if (handshake_c && kind_q == KIND_BR && perf_mp_q != 32'hFFFF_FFFF) perf_mp_d = perf_mp_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_q <= '0;
      perf_tk_q <= '0;
      perf_mp_q <= '0;
    end else begin
      perf_br_q <= perf_br_d;
      perf_tk_q <= perf_tk_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  assign perf_branches_o = perf_br_q;
  assign perf_taken_o    = perf_tk_q;
  assign perf_mispred_o  = perf_mp_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl (default FLUSH_CYCLES=2).
module tb_branch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid_i, op_ready_o, pred_taken_i;
  logic [1:0]  kind_i;
  logic [2:0]  fun3_i;
  logic [31:0] pc_i, imm_i, op_a_i, op_b_i;
  logic        redir_valid_o, redir_ready_i, flush_o, done_o, taken_o, misalign_o, illegal_o;
  logic [31:0] redir_pc_o, link_o;
`ifdef BRANCH_CTRL_PERF_EN
  logic [31:0] perf_branches_o, perf_taken_o, perf_mispred_o;
`endif
  int checks   = 0;
  int failures = 0;

  branch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .kind_i(kind_i), .fun3_i(fun3_i), .pc_i(pc_i), .imm_i(imm_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .pred_taken_i(pred_taken_i),
    .redir_valid_o(redir_valid_o), .redir_ready_i(redir_ready_i),
    .redir_pc_o(redir_pc_o), .flush_o(flush_o), .done_o(done_o),
    .taken_o(taken_o), .link_o(link_o), .misalign_o(misalign_o),
`ifdef BRANCH_CTRL_PERF_EN
    .perf_branches_o(perf_branches_o), .perf_taken_o(perf_taken_o),
    .perf_mispred_o(perf_mispred_o),
`endif
    .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Offer one op for a single accept edge; returns positioned in the EVAL cycle.
  task automatic issue(input logic [1:0] k, input logic [2:0] f, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                       input logic pred);
    op_valid_i = 1'b1; kind_i = k; fun3_i = f; pc_i = pc; imm_i = imm;
    op_a_i = a; op_b_i = b; pred_taken_i = pred;
    tick();
    op_valid_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; op_valid_i = 1'b0; kind_i = '0; fun3_i = '0; pc_i = '0; imm_i = '0;
    op_a_i = '0; op_b_i = '0; pred_taken_i = 1'b0; redir_ready_i = 1'b1;
    tick(); tick();
    chk("rst_op_ready", 32'(op_ready_o), 32'd1);
    chk("rst_redir_valid", 32'(redir_valid_o), 32'd0);
    chk("rst_flush", 32'(flush_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_taken", 32'(taken_o), 32'd0);
    chk("rst_link", link_o, 32'd0);
    chk("rst_redir_pc", redir_pc_o, 32'd0);
    chk("rst_misalign_illegal", {30'd0, misalign_o, illegal_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // BEQ taken, predicted not taken -> redirect 0x120
    chk("beq_ready", 32'(op_ready_o), 32'd1);
    issue(2'b00, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0);
    chk("beq_eval_done", 32'(done_o), 32'd0);
    chk("beq_eval_taken", 32'(taken_o), 32'd1);
    chk("beq_eval_rv", 32'(redir_valid_o), 32'd0);
    chk("beq_eval_ready", 32'(op_ready_o), 32'd0);
    tick();
    chk("beq_rv", 32'(redir_valid_o), 32'd1);
    chk("beq_rpc", redir_pc_o, 32'h120);
    chk("beq_done", 32'(done_o), 32'd1);
    chk("beq_link", link_o, 32'h104);
    tick();
    chk("beq_flush1", 32'(flush_o), 32'd1);
    chk("beq_flush1_ready", 32'(op_ready_o), 32'd0);
    chk("beq_flush1_rpc", redir_pc_o, 32'd0);
    chk("beq_flush1_rv", 32'(redir_valid_o), 32'd0);
    tick();
    chk("beq_flush2", 32'(flush_o), 32'd1);
    tick();
    chk("beq_end_flush", 32'(flush_o), 32'd0);
    chk("beq_end_ready", 32'(op_ready_o), 32'd1);
    chk("beq_hold_taken", 32'(taken_o), 32'd1);

    // BLT signed: -1 < 1 taken, predicted taken -> no redirect
    issue(2'b00, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1);
    chk("blt_done", 32'(done_o), 32'd1);
    chk("blt_taken", 32'(taken_o), 32'd1);
    chk("blt_link", link_o, 32'h204);
    tick();
    chk("blt_ready", 32'(op_ready_o), 32'd1);
    chk("blt_done_pulse", 32'(done_o), 32'd0);
    chk("blt_rv", 32'(redir_valid_o), 32'd0);
    chk("blt_hold_taken", 32'(taken_o), 32'd1);

    // BLTU: 0xFFFFFFFF < 1 false, predicted taken -> recover to pc+4
    issue(2'b00, 3'b110, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1);
    chk("bltu_taken", 32'(taken_o), 32'd0);
    chk("bltu_done", 32'(done_o), 32'd0);
    tick();
    chk("bltu_rv", 32'(redir_valid_o), 32'd1);
    chk("bltu_rpc", redir_pc_o, 32'h204);
    tick(); tick(); tick();
    chk("bltu_ready", 32'(op_ready_o), 32'd1);

    // BGE signed: -1 >= 1 false, predicted not taken -> no redirect
    issue(2'b00, 3'b101, 32'h240, 32'h8, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("bge_done", 32'(done_o), 32'd1);
    chk("bge_taken", 32'(taken_o), 32'd0);
    tick();
    chk("bge_rv", 32'(redir_valid_o), 32'd0);

    // JALR to 0x202 -> misaligned, no redirect
    issue(2'b10, 3'b000, 32'h300, 32'h0, 32'h203, 32'd0, 1'b1);
    chk("jalr_mis", 32'(misalign_o), 32'd1);
    chk("jalr_mis_done", 32'(done_o), 32'd1);
    tick();
    chk("jalr_mis_rv", 32'(redir_valid_o), 32'd0);
    chk("jalr_mis_pulse", 32'(misalign_o), 32'd0);
    chk("jalr_mis_ready", 32'(op_ready_o), 32'd1);

    // JALR 0x201 -> bit0 cleared, redirect 0x200
    issue(2'b10, 3'b000, 32'h300, 32'h0, 32'h201, 32'd0, 1'b1);
    chk("jalr_link", link_o, 32'h304);
    chk("jalr_nomis", 32'(misalign_o), 32'd0);
    tick();
    chk("jalr_rpc", redir_pc_o, 32'h200);
    tick(); tick(); tick();

    // Stalled redirect: ready low for 3 REDIR cycles, new op offered and ignored
    redir_ready_i = 1'b0;
    issue(2'b00, 3'b001, 32'h400, 32'h10, 32'd1, 32'd2, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      op_valid_i = 1'b1; pc_i = 32'h999; kind_i = 2'b01;
      #1;
      chk("stall_rv", 32'(redir_valid_o), 32'd1);
      chk("stall_rpc", redir_pc_o, 32'h410);
      chk("stall_done", 32'(done_o), 32'd0);
      chk("stall_ready", 32'(op_ready_o), 32'd0);
      tick();
    end
    op_valid_i = 1'b0;
    chk("stall_rv4", 32'(redir_valid_o), 32'd1);
    chk("stall_flush_pre", 32'(flush_o), 32'd0);
    redir_ready_i = 1'b1;
    #1;
    chk("stall_hs_done", 32'(done_o), 32'd1);
    chk("stall_hs_rpc", redir_pc_o, 32'h410);
    tick();
    chk("stall_flush1", 32'(flush_o), 32'd1);
    tick();
    chk("stall_flush2", 32'(flush_o), 32'd1);
    tick();
    chk("stall_ready_end", 32'(op_ready_o), 32'd1);

    // Illegal fun3 010
    issue(2'b00, 3'b010, 32'h500, 32'h8, 32'd3, 32'd3, 1'b1);
    chk("ill_pulse", 32'(illegal_o), 32'd1);
    chk("ill_done", 32'(done_o), 32'd1);
    chk("ill_taken", 32'(taken_o), 32'd0);
    tick();
    chk("ill_clear", 32'(illegal_o), 32'd0);
    chk("ill_rv", 32'(redir_valid_o), 32'd0);
    chk("ill_ready", 32'(op_ready_o), 32'd1);

    // JAL then reset during FLUSH
    issue(2'b01, 3'b000, 32'h500, 32'h100, 32'd0, 32'd0, 1'b1);
    chk("jal_taken", 32'(taken_o), 32'd1);
    chk("jal_link", link_o, 32'h504);
    tick();
    chk("jal_rpc", redir_pc_o, 32'h600);
    tick();
    chk("jal_flush", 32'(flush_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_flush", 32'(flush_o), 32'd0);
    chk("mrst_ready", 32'(op_ready_o), 32'd1);
    chk("mrst_taken", 32'(taken_o), 32'd0);
    chk("mrst_link", link_o, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_after_ready", 32'(op_ready_o), 32'd1);
    chk("mrst_after_flush", 32'(flush_o), 32'd0);

    // BNE with wrap-around target
    issue(2'b00, 3'b001, 32'hFFFF_FFF0, 32'h20, 32'd1, 32'd0, 1'b0);
    chk("wrap_taken", 32'(taken_o), 32'd1);
    chk("wrap_link", link_o, 32'hFFFF_FFF4);
    tick();
    chk("wrap_rpc", redir_pc_o, 32'h0000_0010);
    tick(); tick(); tick();
    chk("wrap_ready", 32'(op_ready_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
